// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit owning architectural HI/LO
//
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) in a fixed 33-cycle
// sequence and holds the HI/LO pair. MTHI/MTLO writes are accepted while idle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   cancel            abort the in-flight operation
//   hi_we, lo_we      MTHI / MTLO strobes, data on wdata
//   busy              operation in flight
//   done              one-cycle pulse, HI/LO written this cycle
//   div_by_zero       valid with done, divisor was zero
//   hi, lo            architectural HI/LO
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;     // partial product high half / remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] operand_b;  // multiplicand magnitude / divisor magnitude
  logic             is_div;
  logic             neg_res;    // product or quotient must be negated
  logic             neg_rem;    // remainder must be negated (dividend was negative)
  logic             zero_div;

  // Operand capture: signed ops work on magnitudes, sign restored in FIX.
  logic             signed_op, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign signed_op = ~op[0];
  assign neg_a     = signed_op & src_a[WIDTH-1];
  assign neg_b     = signed_op & src_b[WIDTH-1];
  assign mag_a     = neg_a ? -src_a : src_a;
  assign mag_b     = neg_b ? -src_b : src_b;

  // One shift-add multiply step: add multiplicand when the current LSB is set,
  // then shift the 2*WIDTH+1 bit accumulator right by one.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);

  // One restoring divide step: shift in the next dividend bit, trial subtract.
  // Two guard bits because the shifted remainder can reach 2**(WIDTH+1)-1.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, operand_b};
  assign div_ok    = ~div_diff[WIDTH+1];

  // Sign fix-up of the finished result.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cancel) state_nxt = IDLE;
               else if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    if (state != IDLE) busy = 1'b1;
  end

  // Datapath and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      operand_b   <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            // start wins over a coincident MTHI/MTLO or cancel
            acc_hi    <= '0;
            acc_lo    <= mag_a;
            operand_b <= mag_b;
            is_div    <= op[1];
            neg_res   <= neg_a ^ neg_b;
            neg_rem   <= neg_a & op[1];
            zero_div  <= (src_b == '0);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (cancel || cnt == CNT_W'(WIDTH-1)) cnt <= '0;
          else                                  cnt <= cnt + 1'b1;
          if (!cancel) begin
            if (is_div) begin
              acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          cnt <= '0;
          if (!cancel) begin
            done        <= 1'b1;
            div_by_zero <= is_div & zero_div;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (zero_div) begin
              // Remainder path already holds |dividend|; rem_fix restores src_a.
              lo <= '1;
              hi <= rem_fix;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // Drives one operation (entered 1ns after a rising edge), scrambles the
  // inputs after capture, and waits for done with a cycle bound.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_low);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom; op = ~o;
    lat = 0; busy_low = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi actual=%h required=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo actual=%h required=0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz actual=%b required=0", div_by_zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat, bl;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bl);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency actual=%0d required=33", lat); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi actual=%h required=fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo actual=%h required=00000001", lo); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL multu_dbz actual=%b required=0", div_by_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done actual=%b required=0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse actual=%b required=0", done); end
  endtask

  task automatic test_mult();
    int lat, bl;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bl);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency actual=%0d required=33", lat); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL mult_busy_cycles actual_low=%0d required_low=0", bl); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi actual=%h required=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo actual=%h required=ffffffeb", lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int lat, bl;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bl);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_signed_lo actual=%h required=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_signed_hi actual=%h required=ffffffff", hi); end
    @(posedge clk); #1;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bl);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency actual=%0d required=33", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo actual=%h required=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi actual=%h required=00000002", hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat, bl;
    run_op(OP_DIVU, 32'd5, 32'd0, lat, bl);
    checks++; if (lat !== 33) begin errors++; $display("FAIL dbz_latency actual=%0d required=33", lat); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo actual=%h required=ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL dbz_hi actual=%h required=00000005", hi); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag actual=%b required=1", div_by_zero); end
    repeat (3) @(posedge clk); #1;
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_hold actual=%b required=1", div_by_zero); end
    run_op(OP_MULT, 32'd2, 32'd2, lat, bl);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear actual=%b required=0", div_by_zero); end
    checks++; if (lo !== 32'd4 || hi !== 32'd0) begin errors++; $display("FAIL mult_2x2 actual=%h_%h required=00000000_00000004", hi, lo); end
    @(posedge clk); #1;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bl);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo actual=%h required=80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi actual=%h required=00000000", hi); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dbz actual=%b required=0", div_by_zero); end
    @(posedge clk); #1;
    run_op(OP_DIV, 32'hFFFF_FFF7, 32'd0, lat, bl);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_signed_lo actual=%h required=ffffffff", lo); end
    checks++; if (hi !== 32'hFFFF_FFF7) begin errors++; $display("FAIL dbz_signed_hi actual=%h required=fffffff7", hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start();
    int dones = 0;
    op = OP_MULTU; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (cyc == 10) begin
        start = 1'b1; op = OP_DIVU; src_a = 32'd9; src_b = 32'd4;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_start_dones actual=%0d required=1", dones); end
    checks++; if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL busy_start_result actual=%h_%h required=00000000_0000002a", hi, lo); end
  endtask

  task automatic test_cancel();
    int dones = 0;
    logic busy_after = 1'b1;
    op = OP_DIVU; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      cancel = (cyc == 15);
      if (done === 1'b1) dones++;
      if (cyc == 16) busy_after = busy;
      @(posedge clk); #1;
    end
    cancel = 1'b0;
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL cancel_busy actual=%b required=0", busy_after); end
    checks++; if (dones !== 0) begin errors++; $display("FAIL cancel_dones actual=%0d required=0", dones); end
    checks++; if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL cancel_hilo actual=%h_%h required=00000000_0000002a", hi, lo); end
  endtask

  task automatic test_reset_mid();
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid_ctrl actual=busy%b_done%b required=busy0_done0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_mid_hilo actual=%h_%h required=00000000_00000000", hi, lo); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mt();
    int lat = 0;
    lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo actual=%h required=00001234", lo); end
    hi_we = 1'b1; wdata = 32'h55;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++; if (hi !== 32'h55) begin errors++; $display("FAIL mthi actual=%h required=00000055", hi); end
    // start together with MTLO: start wins
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd5; start = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL start_beats_mtlo actual=%h required=00001234", lo); end
    hi_we = 1'b1; wdata = 32'hAA;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++; if (hi !== 32'h55) begin errors++; $display("FAIL mthi_busy actual=%h required=00000055", hi); end
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lo !== 32'd15 || hi !== 32'd0) begin errors++; $display("FAIL mt_followup_mul actual=%h_%h required=00000000_0000000f", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_start();
    test_cancel();
    test_reset_mid();
    test_mt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
